// File: rtl/gf_pkg.sv
// Shared GF(2^8) constants for the Reed-Solomon datapath (field poly 0x11D)
// and the state encoding of the iterative inverter.
package gf_pkg;

   localparam int unsigned GF_M             = 8;
   localparam logic [7:0]  GF_POLY_LOW      = 8'h1D;
   localparam logic [7:0]  GF_ONE           = 8'h01;
   localparam int unsigned GF_INV_EXP_STEPS = 7;
   localparam int unsigned GF_CNT_W         = $clog2(GF_INV_EXP_STEPS + 1);

   localparam int unsigned GF_ST_W = 2;
   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_RUN  = 2'd1;
   localparam logic [1:0]  ST_FIN  = 2'd2;

endpackage

// File: rtl/gf_mul_comb.sv
// Combinational GF(2^8) multiplier: MSB-first shift-and-add with reduction
// by the low taps of the field polynomial.
module gf_mul_comb
   import gf_pkg::*;
(
   input  logic [GF_M-1:0] a,
   input  logic [GF_M-1:0] b,
   output logic [GF_M-1:0] prod_c
);

   logic [GF_M-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = GF_M - 1; i >= 0; i--) begin
         acc = {acc[GF_M-2:0], 1'b0} ^ (acc[GF_M-1] ? GF_POLY_LOW : '0);
         if (b[i]) begin
            acc = acc ^ a;
         end
      end
      prod_c = acc;
   end

endmodule

// File: rtl/gf_inv.sv
// Iterative GF(2^8) inverter, out = a^254 by square-and-multiply with a
// start/done handshake. Optional zero_err port under GF_INV_ZERO_FLAG_EN.
module gf_inv
   import gf_pkg::*;
#(
   parameter int unsigned MUL_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [GF_M-1:0] in_1,
   output logic [GF_M-1:0] out,
   output logic            done,
   output logic            busy
`ifdef GF_INV_ZERO_FLAG_EN
   ,
   output logic            zero_err
`endif
);

   localparam logic [GF_CNT_W-1:0] CNT_LAST = GF_CNT_W'(GF_INV_EXP_STEPS - 1);

   logic [GF_ST_W-1:0]  state_q, state_d;
   logic [GF_M-1:0]     sq_q, sq_d;
   logic [GF_M-1:0]     res_q, res_d;
   logic [GF_CNT_W-1:0] cnt_q, cnt_d;
   logic                phase_q, phase_d;
   logic [GF_M-1:0]     out_q, out_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                last_step;
   logic [GF_M-1:0]     prod0_c;
   logic [GF_M-1:0]     prod1_c;
`ifdef GF_INV_ZERO_FLAG_EN
   logic [GF_M-1:0]     a_q, a_d;
   logic                zero_err_q, zero_err_d;
`endif

   // P=1 shares one multiplier between square (phase 0) and multiply (phase 1)
   if (MUL_PER_CYCLE == 1) begin : g_p1
      gf_mul_comb u_mul0 (
         .a      (phase_q ? res_q : sq_q),
         .b      (sq_q),
         .prod_c (prod0_c)
      );
      assign prod1_c = '0;
   end else if (MUL_PER_CYCLE == 2) begin : g_p2
      gf_mul_comb u_mul0 (
         .a      (sq_q),
         .b      (sq_q),
         .prod_c (prod0_c)
      );
      gf_mul_comb u_mul1 (
         .a      (res_q),
         .b      (prod0_c),
         .prod_c (prod1_c)
      );
   end else begin : g_bad
      $error("gf_inv: MUL_PER_CYCLE must be 1 or 2");
   end

   always_comb begin
      state_d   = state_q;
      sq_d      = sq_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      out_d     = out_q;
      done_d    = 1'b0;
      busy_d    = busy_q;
      last_step = 1'b0;
`ifdef GF_INV_ZERO_FLAG_EN
      a_d        = a_q;
      zero_err_d = zero_err_q;
`endif
      case (state_q)
         ST_RUN: begin
            if (MUL_PER_CYCLE == 1) begin
               if (!phase_q) begin
                  sq_d    = prod0_c;
                  phase_d = 1'b1;
               end else begin
                  res_d     = prod0_c;
                  cnt_d     = cnt_q + GF_CNT_W'(1);
                  phase_d   = 1'b0;
                  last_step = (cnt_q == CNT_LAST);
               end
            end else begin
               sq_d      = prod0_c;
               res_d     = prod1_c;
               cnt_d     = cnt_q + GF_CNT_W'(1);
               last_step = (cnt_q == CNT_LAST);
            end
            // Result is published on entry to FIN so done and out share a cycle
            if (last_step) begin
               state_d = ST_FIN;
               out_d   = res_d;
               done_d  = 1'b1;
               busy_d  = 1'b0;
`ifdef GF_INV_ZERO_FLAG_EN
               zero_err_d = (a_q == '0);
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (start && !busy_q) begin
               state_d = ST_RUN;
               sq_d    = in_1;
               res_d   = GF_ONE;
               cnt_d   = '0;
               phase_d = 1'b0;
               busy_d  = 1'b1;
`ifdef GF_INV_ZERO_FLAG_EN
               a_d = in_1;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sq_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         out_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef GF_INV_ZERO_FLAG_EN
         a_q        <= '0;
         zero_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sq_q    <= sq_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         out_q   <= out_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef GF_INV_ZERO_FLAG_EN
         a_q        <= a_d;
         zero_err_q <= zero_err_d;
`endif
      end
   end

   assign out  = out_q;
   assign done = done_q;
   assign busy = busy_q;
`ifdef GF_INV_ZERO_FLAG_EN
   assign zero_err = zero_err_q;
`endif

endmodule

// File: tb/tb_gf_inv.sv
// Bench for gf_inv: both MUL_PER_CYCLE builds side by side, checked against a
// brute-force GF(2^8) inverse model. Honours GF_INV_ZERO_FLAG_EN.
module tb_gf_inv;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1, start2;
   logic [7:0] in1, in2;
   logic [7:0] out1, out2;
   logic       done1, done2, busy1, busy2;
`ifdef GF_INV_ZERO_FLAG_EN
   logic       ze1, ze2;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   gf_inv #(.MUL_PER_CYCLE(1)) u_p1 (
      .clk      (clk),
      .rst      (rst),
      .start    (start1),
      .in_1     (in1),
      .out      (out1),
      .done     (done1),
      .busy     (busy1)
`ifdef GF_INV_ZERO_FLAG_EN
      ,
      .zero_err (ze1)
`endif
   );

   gf_inv #(.MUL_PER_CYCLE(2)) u_p2 (
      .clk      (clk),
      .rst      (rst),
      .start    (start2),
      .in_1     (in2),
      .out      (out2),
      .done     (done2),
      .busy     (busy2)
`ifdef GF_INV_ZERO_FLAG_EN
      ,
      .zero_err (ze2)
`endif
   );

   // Reference: carry-less product reduced mod 0x11D
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011D << (k - 8));
      return p[7:0];
   endfunction

   // Reference inverse by exhaustive search; 0 maps to 0
   function automatic logic [7:0] ref_inv(input logic [7:0] a);
      if (a == 8'h00) return 8'h00;
      for (int b = 1; b < 256; b++) if (ref_mul(a, 8'(b)) == 8'h01) return 8'(b);
      return 8'h00;
   endfunction

   function automatic int lat_of(input int p);
      return (p == 1) ? 15 : 8;
   endfunction

   function automatic logic get_done(input int p);
      return (p == 1) ? done1 : done2;
   endfunction

   function automatic logic get_busy(input int p);
      return (p == 1) ? busy1 : busy2;
   endfunction

   function automatic logic [7:0] get_out(input int p);
      return (p == 1) ? out1 : out2;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic s, input logic [7:0] a);
      if (p == 1) begin
         start1 = s;
         in1    = a;
      end else begin
         start2 = s;
         in2    = a;
      end
   endtask

   // One operation from an idle cycle; returns cycle of done relative to accept (-1 on timeout)
   task automatic run_op(input int p, input logic [7:0] a, output int lat,
                         output logic [7:0] o, output logic ze, output int busy_err,
                         output logic busy_at_done, output logic done_next);
      lat = -1; o = 8'hxx; ze = 1'b0; busy_err = 0; busy_at_done = 1'bx;
      drive(p, 1'b1, a);
      tick();
      drive(p, 1'b0, 8'($urandom));
      for (int n = 1; n <= 40; n++) begin
         if (get_done(p)) begin
            lat          = n;
            o            = get_out(p);
            busy_at_done = get_busy(p);
`ifdef GF_INV_ZERO_FLAG_EN
            ze = (p == 1) ? ze1 : ze2;
`endif
            break;
         end
         if (get_busy(p) !== 1'b1) busy_err++;
         tick();
      end
      tick();
      done_next = get_done(p);
   endtask

   task automatic test_reset();
      int dones;
      rst = 1'b1;
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      tick();
      tick();
      for (int p = 1; p <= 2; p++) begin
         tests_run++;
         if (get_out(p) !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_out p=%0d got=%h exp=00", p, get_out(p));
         end
         tests_run++;
         if (get_done(p) !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done p=%0d got=%b exp=0", p, get_done(p));
         end
         tests_run++;
         if (get_busy(p) !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy p=%0d got=%b exp=0", p, get_busy(p));
         end
      end
      rst = 1'b0;
      tick();
      // Abort mid-operation: start at T, rst during T+5
      drive(1, 1'b1, 8'h02);
      tick();
      drive(1, 1'b0, 8'h00);
      for (int n = 1; n < 5; n++) tick();
      tests_run++;
      if (busy1 !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_busy_before got=%b exp=1", busy1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests_run++;
      if (busy1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_busy_after got=%b exp=0", busy1);
      end
      dones = 0;
      for (int n = 0; n < 20; n++) begin
         if (done1) dones++;
         tick();
      end
      tests_run++;
      if (dones !== 0) begin
         tests_failed++;
         $display("FAIL midreset_no_done got=%0d dones exp=0", dones);
      end
   endtask

   task automatic test_known(input int p, input logic [7:0] a, input logic [7:0] exp);
      int lat, be;
      logic [7:0] o;
      logic ze, bd, dn;
      run_op(p, a, lat, o, ze, be, bd, dn);
      tests_run++;
      if (o !== exp) begin
         tests_failed++;
         $display("FAIL known_out p=%0d a=%h got=%h exp=%h", p, a, o, exp);
      end
      tests_run++;
      if (lat !== lat_of(p)) begin
         tests_failed++;
         $display("FAIL known_latency p=%0d a=%h got=%0d exp=%0d", p, a, lat, lat_of(p));
      end
      tests_run++;
      if (be !== 0 || bd !== 1'b0) begin
         tests_failed++;
         $display("FAIL known_busy p=%0d low_cycles=%0d busy_at_done=%b exp=0/0", p, be, bd);
      end
      tests_run++;
      if (dn !== 1'b0) begin
         tests_failed++;
         $display("FAIL known_done_width p=%0d done_next=%b exp=0", p, dn);
      end
   endtask

   task automatic test_zero();
      int lat, be;
      logic [7:0] o;
      logic ze, bd, dn;
      for (int p = 1; p <= 2; p++) begin
         run_op(p, 8'h00, lat, o, ze, be, bd, dn);
         tests_run++;
         if (o !== 8'h00 || lat !== lat_of(p)) begin
            tests_failed++;
            $display("FAIL zero_out p=%0d got=%h lat=%0d exp=00 lat=%0d", p, o, lat, lat_of(p));
         end
`ifdef GF_INV_ZERO_FLAG_EN
         tests_run++;
         if (ze !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_flag_set p=%0d got=%b exp=1", p, ze);
         end
         tests_run++;
         if (((p == 1) ? ze1 : ze2) !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_flag_hold p=%0d exp=1", p);
         end
`endif
         run_op(p, 8'h02, lat, o, ze, be, bd, dn);
         tests_run++;
         if (o !== 8'h8E) begin
            tests_failed++;
            $display("FAIL zero_followup_out p=%0d got=%h exp=8e", p, o);
         end
`ifdef GF_INV_ZERO_FLAG_EN
         tests_run++;
         if (ze !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_flag_clear p=%0d got=%b exp=0", p, ze);
         end
`endif
      end
   endtask

   task automatic test_ignore_busy();
      int lat, dones;
      logic [7:0] o;
      lat = -1;
      o = 8'hxx;
      drive(1, 1'b1, 8'h02);
      tick();
      drive(1, 1'b0, 8'h00);
      for (int n = 1; n <= 40; n++) begin
         if (n == 3) drive(1, 1'b1, 8'h55);
         else        drive(1, 1'b0, 8'h00);
         if (done1) begin
            lat = n;
            o   = out1;
            break;
         end
         tick();
      end
      drive(1, 1'b0, 8'h00);
      tests_run++;
      if (lat !== 15 || o !== 8'h8E) begin
         tests_failed++;
         $display("FAIL ignore_busy_result got=%h lat=%0d exp=8e lat=15", o, lat);
      end
      tick();
      dones = 0;
      for (int n = 0; n < 25; n++) begin
         if (done1) dones++;
         tick();
      end
      tests_run++;
      if (dones !== 0) begin
         tests_failed++;
         $display("FAIL ignore_busy_no_extra got=%0d dones exp=0", dones);
      end
   endtask

   task automatic test_back_to_back(input int p);
      logic [7:0] a1, a2, o1, o2;
      int lat1, lat2;
      a1 = 8'($urandom_range(1, 255));
      a2 = 8'($urandom_range(1, 255));
      lat1 = -1; lat2 = -1; o1 = 8'hxx; o2 = 8'hxx;
      drive(p, 1'b1, a1);
      tick();
      drive(p, 1'b0, 8'h00);
      for (int n = 1; n <= 40; n++) begin
         if (get_done(p)) begin
            lat1 = n;
            o1   = get_out(p);
            break;
         end
         tick();
      end
      drive(p, 1'b1, a2);
      tick();
      drive(p, 1'b0, 8'h00);
      for (int n = 1; n <= 40; n++) begin
         if (get_done(p)) begin
            lat2 = n;
            o2   = get_out(p);
            break;
         end
         tick();
      end
      tick();
      tests_run++;
      if (lat1 !== lat_of(p) || o1 !== ref_inv(a1)) begin
         tests_failed++;
         $display("FAIL b2b_first p=%0d a=%h got=%h lat=%0d exp=%h lat=%0d",
                  p, a1, o1, lat1, ref_inv(a1), lat_of(p));
      end
      tests_run++;
      if (lat2 !== lat_of(p) || o2 !== ref_inv(a2)) begin
         tests_failed++;
         $display("FAIL b2b_second p=%0d a=%h got=%h lat=%0d exp=%h lat=%0d",
                  p, a2, o2, lat2, ref_inv(a2), lat_of(p));
      end
   endtask

   task automatic test_sweep();
      int lat, be;
      logic [7:0] o;
      logic ze, bd, dn;
      for (int p = 1; p <= 2; p++) begin
         for (int a = 1; a < 256; a++) begin
            run_op(p, 8'(a), lat, o, ze, be, bd, dn);
            tests_run++;
            if (o !== ref_inv(8'(a)) || ref_mul(o, 8'(a)) !== 8'h01) begin
               tests_failed++;
               $display("FAIL sweep_out p=%0d a=%h got=%h exp=%h", p, 8'(a), o, ref_inv(8'(a)));
            end
            tests_run++;
            if (lat !== lat_of(p) || be !== 0) begin
               tests_failed++;
               $display("FAIL sweep_timing p=%0d a=%h lat=%0d busy_low=%0d exp lat=%0d busy_low=0",
                        p, 8'(a), lat, be, lat_of(p));
            end
            tests_run++;
            if (dn !== 1'b0) begin
               tests_failed++;
               $display("FAIL sweep_done_width p=%0d a=%h done_next=%b exp=0", p, 8'(a), dn);
            end
         end
      end
   endtask

   task automatic test_random();
      int lat, be, p, gap;
      logic [7:0] a, o;
      logic ze, bd, dn;
      for (int k = 0; k < 40; k++) begin
         p   = int'($urandom_range(1, 2));
         a   = 8'($urandom);
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) tick();
         run_op(p, a, lat, o, ze, be, bd, dn);
         tests_run++;
         if (o !== ref_inv(a) || lat !== lat_of(p)) begin
            tests_failed++;
            $display("FAIL random p=%0d a=%h got=%h lat=%0d exp=%h lat=%0d",
                     p, a, o, lat, ref_inv(a), lat_of(p));
         end
      end
   endtask

   initial begin
      rst    = 1'b1;
      start1 = 1'b0;
      start2 = 1'b0;
      in1    = 8'h00;
      in2    = 8'h00;
      test_reset();
      test_known(1, 8'h02, 8'h8E);
      test_known(1, 8'h8E, 8'h02);
      test_known(2, 8'h03, 8'hF4);
      test_known(2, 8'h04, 8'h47);
      test_known(2, 8'h01, 8'h01);
      test_zero();
      test_ignore_busy();
      test_back_to_back(1);
      test_back_to_back(2);
      test_sweep();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/gf_inv.md
Name: gf_inv

Overview:
- Iterative GF(2^8) multiplicative inverter for the Reed-Solomon decoder datapath. It is the inverse operation of the field multiplier.
- Field polynomial: x^8 + x^4 + x^3 + x^2 + 1 (0x11D).
- Computes out = a^254 by square-and-multiply. Used by the error-value and Forney stages to turn a division into inverse-then-multiply.
- Start/done handshake; fixed latency.

Parameters:
- MUL_PER_CYCLE, 1, number of field multiplies per cycle. 1 means square and multiply alternate on one multiplier. 2 means square then multiply are chained combinationally in one cycle. Other values are illegal; elaboration must error.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- in_1  input  8  operand a, sampled in the accept cycle.
- out  output  8  inverse of a, valid from the done cycle and held until the next done.
- done  output  1  single-cycle pulse, result valid.
- busy  output  1  high while an inversion is in progress.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, out=0, done=0, busy=0, counter=0. Reset mid-operation aborts the operation; no done is produced.
- Accept: in cycle T, start=1 && busy=0 latches a_reg=in_1, sq=in_1, res=8'h01, cnt=0 and enters RUN. start while busy=1 is ignored, with no queueing.
- LAT = 14/MUL_PER_CYCLE + 1. That is 15 for P=1 and 8 for P=2.
- busy is high for cycles T+1 .. T+LAT-1 and low at T+LAT.
- done=1 only at T+LAT; out updates at T+LAT. A new start is accepted in the done cycle (back-to-back), so the next done comes at T+2*LAT.
- FSM states: IDLE, RUN, FIN.
  - P=1, RUN alternates phases. SQR: sq <= sq*sq. MUL: res <= res*sq, cnt++. After 7 SQR/MUL pairs (cnt==7), go to FIN.
  - P=2, RUN does one step per cycle: sq <= sq*sq; res <= res*(sq*sq); cnt++. After cnt==7, go to FIN.
  - FIN: out <= res, done=1, go to IDLE, busy=0. A start accepted in FIN is evaluated as from IDLE.
- Arithmetic:
  - Multiplication is polynomial mod 0x11D with 8-bit results.
  - The squaring sequence produces a^2, a^4 … a^128, so res = a^(2+4+…+128) = a^254.
- a=0 gives out=0 naturally; no special path.
- Inputs are not required to be held after acceptance.

Optional Feature:
- GF_INV_ZERO_FLAG_EN defined:
  - Adds output port zero_err (1 bit), reset 0.
  - zero_err is registered equal to (a_reg==0) and updates in the done cycle alongside out.
  - It holds until the next done.
- Not defined: the port is absent and no zero-detect logic is generated. Timing is identical in both cases.

Decomposition:
- Shared package gf_pkg holds:
  - GF_M=8
  - GF_POLY_LOW=8'h1D (reduction taps)
  - GF_ONE=8'h01
  - GF_INV_EXP_STEPS=7
  - FSM state encoding constants
- Sub-module gf_mul_comb: purely combinational 8x8 multiply with reduction by GF_POLY_LOW. gf_inv instantiates it once when P=1 and twice (chained) when P=2.

Test Plan:
- Reset then idle: out=0, done=0, busy=0. With P=1, assert rst at T+5 mid-operation: no done follows, busy=0 the next cycle.
- P=1, in_1=8'h02, start at T: done exactly at T+15, out=8'h8E, busy high T+1..T+14. Then in_1=8'h8E gives 8'h02.
- P=2, in_1=8'h03 gives out=8'hF4 at T+8; in_1=8'h04 gives 8'h47; in_1=8'h01 gives 8'h01.
- in_1=8'h00 gives out=8'h00. With GF_INV_ZERO_FLAG_EN, zero_err=1. Next op with in_1=8'h02 sets zero_err=0.
- start pulsed at T+3 during busy with in_1=8'h55: ignored, result of original operand only. Start in the done cycle is accepted: second done at T+2*LAT.
- Exhaustive sweep a=1..255 in both P values against a reference model: out*a==1 for all. Each done is exactly one cycle wide.
